// File: rtl/lcd_read_control.sv
// HD44780-style 4-bit read controller (RW=1): reads BF/AC or one RAM byte,
// with an optional busy-flag poll loop bounded by a cycle timeout.
module lcd_read_control #(
  parameter int SETUP_CYCLES      = 2,
  parameter int E_HIGH_CYCLES     = 12,
  parameter int HOLD_CYCLES       = 1,
  parameter int NIBBLE_GAP_CYCLES = 50,
  parameter int POLL_TIMEOUT      = 100000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iRead_Request,
  input  logic       iRegisterSelect,
  input  logic       iPoll,
  input  logic [3:0] iLCD_Data,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_ReadWrite,
  output logic       oLCD_StrataFlashControl,
  output logic       oBusy,
  output logic       oRead_Valid,
  output logic [7:0] oRead_Data,
  output logic       oBusyFlag,
  output logic [6:0] oAddress,
  output logic       oTimeout,
  output logic [3:0] oState
);

  // Request/response handshake: iRead_Request is accepted only in IDLE; oBusy
  // stays high until the IDLE cycle after the single-cycle oRead_Valid or
  // oTimeout pulse, and oRead_Data is valid from that pulse onward.

  typedef enum logic [3:0] {
    IDLE, SETUP_H, E_H, HOLD_H, GAP, SETUP_L, E_L, HOLD_L, DONE
  } stateType;

  localparam logic [15:0] SetupLast = 16'(SETUP_CYCLES - 1);
  localparam logic [15:0] EHighLast = 16'(E_HIGH_CYCLES - 1);
  localparam logic [15:0] HoldLast  = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] GapLast   = 16'(NIBBLE_GAP_CYCLES - 1);
  localparam logic [31:0] PollLimit = 32'(POLL_TIMEOUT);

  stateType    state, nextState;
  logic [15:0] stateCount;
  logic [31:0] pollCount;
  logic        rsLatched, pollLatched, gapToHigh;
  logic [3:0]  highNibble, lowNibble;
  logic        pollRetry, pollExpired;

  // Only a BF/AC read can poll, so bit 7 of the result is the busy flag here.
  assign pollExpired = pollCount >= PollLimit;
  assign pollRetry   = pollLatched && oRead_Data[7] && !pollExpired;

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (iRead_Request) nextState = SETUP_H;
      SETUP_H: if (stateCount == SetupLast) nextState = E_H;
      E_H:     if (stateCount == EHighLast) nextState = HOLD_H;
      HOLD_H:  if (stateCount == HoldLast) nextState = GAP;
      GAP:     if (stateCount == GapLast) nextState = gapToHigh ? SETUP_H : SETUP_L;
      SETUP_L: if (stateCount == SetupLast) nextState = E_L;
      E_L:     if (stateCount == EHighLast) nextState = HOLD_L;
      HOLD_L:  if (stateCount == HoldLast) nextState = DONE;
      DONE:    nextState = pollRetry ? GAP : IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      stateCount  <= '0;
      pollCount   <= '0;
      rsLatched   <= 1'b0;
      pollLatched <= 1'b0;
      gapToHigh   <= 1'b0;
      highNibble  <= '0;
      lowNibble   <= '0;
      oRead_Data  <= '0;
      oBusyFlag   <= 1'b0;
      oAddress    <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE || nextState != state) stateCount <= '0;
      else                                      stateCount <= stateCount + 16'd1;

      if (state == IDLE && iRead_Request) begin
        rsLatched   <= iRegisterSelect;
        pollLatched <= iPoll && !iRegisterSelect;
        pollCount   <= '0;
      end else if (state != IDLE && pollLatched && pollCount != '1) begin
        pollCount <= pollCount + 32'd1;
      end

      if (state == HOLD_H) gapToHigh <= 1'b0;
      else if (state == DONE) gapToHigh <= 1'b1;

      if (state == E_H && stateCount == EHighLast) highNibble <= iLCD_Data;
      if (state == E_L && stateCount == EHighLast) lowNibble  <= iLCD_Data;

      // Result registers load on entry to DONE so they line up with the pulse.
      if (state == HOLD_L && stateCount == HoldLast) begin
        oRead_Data <= {highNibble, lowNibble};
        oBusyFlag  <= !rsLatched && highNibble[3];
        oAddress   <= rsLatched ? 7'h00 : {highNibble[2:0], lowNibble};
      end
    end
  end

  assign oLCD_Enabled            = (state == E_H) || (state == E_L);
  assign oLCD_ReadWrite          = (state != IDLE);
  assign oLCD_RegisterSelect     = (state != IDLE) && rsLatched;
  assign oLCD_StrataFlashControl = 1'b1;
  assign oBusy                   = (state != IDLE);
  assign oRead_Valid             = (state == DONE) && !(pollLatched && oRead_Data[7]);
  assign oTimeout                = (state == DONE) && pollLatched && oRead_Data[7] && pollExpired;
  assign oState                  = state;

endmodule

// File: tb/tb_lcd_read_control.sv
// Directed bench for lcd_read_control: table of read transactions against an
// LCD nibble model, plus hand sequences for reset, held and busy-time requests.
module tb_lcd_read_control;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       iRead_Request = 1'b0;
  logic       iRegisterSelect = 1'b0;
  logic       iPoll = 1'b0;
  logic [3:0] iLCD_Data = 4'h0;
  logic       oLCD_Enabled, oLCD_RegisterSelect, oLCD_ReadWrite, oLCD_StrataFlashControl;
  logic       oBusy, oRead_Valid, oBusyFlag, oTimeout;
  logic [7:0] oRead_Data;
  logic [6:0] oAddress;
  logic [3:0] oState;

  lcd_read_control #(.POLL_TIMEOUT(500)) dut (
    .Clock(Clock), .Reset(Reset), .iRead_Request(iRead_Request),
    .iRegisterSelect(iRegisterSelect), .iPoll(iPoll), .iLCD_Data(iLCD_Data),
    .oLCD_Enabled(oLCD_Enabled), .oLCD_RegisterSelect(oLCD_RegisterSelect),
    .oLCD_ReadWrite(oLCD_ReadWrite), .oLCD_StrataFlashControl(oLCD_StrataFlashControl),
    .oBusy(oBusy), .oRead_Valid(oRead_Valid), .oRead_Data(oRead_Data),
    .oBusyFlag(oBusyFlag), .oAddress(oAddress), .oTimeout(oTimeout), .oState(oState)
  );

  always #10 Clock = ~Clock;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // LCD model: the first modelBusy reads return modelBusyByte, later ones modelFinal.
  int         ePulses = 0;
  int         modelBusy = 0;
  logic [7:0] modelBusyByte = 8'h00;
  logic [7:0] modelFinal = 8'h00;
  logic [7:0] modelByte;

  always @(posedge oLCD_Enabled) begin
    modelByte = (ePulses / 2 < modelBusy) ? modelBusyByte : modelFinal;
    iLCD_Data = ePulses[0] ? modelByte[3:0] : modelByte[7:4];
    ePulses++;
  end

  int         txLatency, txGap, txPulses;
  logic       txEnded, txValid, txTimeout, txBusyStart, txBusyAfter, txPulseAfter;
  logic       txWidthOk, txRsOk, txBf;
  logic [7:0] txData;
  logic [6:0] txAddr;

  task automatic runTx(input logic rs, input logic poll, input logic holdReq);
    int   cyc, eHigh, r0, r1;
    logic prevE;
    ePulses = 0;
    @(negedge Clock);
    iRead_Request = 1'b1; iRegisterSelect = rs; iPoll = poll;
    @(posedge Clock);
    @(negedge Clock);
    if (!holdReq) iRead_Request = 1'b0;
    txBusyStart = oBusy;
    cyc = 0; eHigh = 0; r0 = 0; r1 = 0; prevE = 1'b0;
    txPulses = 0; txEnded = 1'b0; txWidthOk = 1'b1; txRsOk = 1'b1;
    txValid = 1'b0; txTimeout = 1'b0;
    while (cyc < 2000) begin
      if (oLCD_Enabled && !prevE) begin
        if (txPulses == 0) r0 = cyc;
        else if (txPulses == 1) r1 = cyc;
        txPulses++;
      end
      if (oLCD_Enabled) eHigh++;
      else if (prevE) begin
        if (eHigh != 12) txWidthOk = 1'b0;
        eHigh = 0;
      end
      prevE = oLCD_Enabled;
      if (oLCD_ReadWrite && oLCD_RegisterSelect !== rs) txRsOk = 1'b0;
      if (oRead_Valid || oTimeout) begin
        txEnded = 1'b1; txValid = oRead_Valid; txTimeout = oTimeout;
        txData = oRead_Data; txBf = oBusyFlag; txAddr = oAddress;
        break;
      end
      @(posedge Clock);
      @(negedge Clock);
      cyc++;
    end
    txLatency = cyc;
    txGap = r1 - r0;
    @(posedge Clock);
    @(negedge Clock);
    txBusyAfter = oBusy;
    txPulseAfter = oRead_Valid | oTimeout;
  endtask

  typedef struct {
    logic       rs;
    logic       poll;
    int         nBusy;
    logic [7:0] busyByte;
    logic [7:0] finalByte;
    logic       expTimeout;
    int         expLatency;
    logic [7:0] expData;
    logic       expBf;
    logic [6:0] expAddr;
    int         expPulses;
  } vecType;

  vecType vecs[7];

  initial begin
    logic idleOk;
    vecs[0] = '{1'b0, 1'b0, 0,    8'h00, 8'hA5, 1'b0, 80,  8'hA5, 1'b1, 7'h25, 2};
    vecs[1] = '{1'b1, 1'b0, 0,    8'h00, 8'h48, 1'b0, 80,  8'h48, 1'b0, 7'h00, 2};
    vecs[2] = '{1'b0, 1'b1, 3,    8'h80, 8'h07, 1'b0, 473, 8'h07, 1'b0, 7'h07, 8};
    vecs[3] = '{1'b1, 1'b1, 0,    8'h00, 8'h9C, 1'b0, 80,  8'h9C, 1'b0, 7'h00, 2};
    vecs[4] = '{1'b0, 1'b1, 0,    8'h00, 8'h3F, 1'b0, 80,  8'h3F, 1'b0, 7'h3F, 2};
    vecs[5] = '{1'b0, 1'b0, 0,    8'h00, 8'hFF, 1'b0, 80,  8'hFF, 1'b1, 7'h7F, 2};
    vecs[6] = '{1'b0, 1'b1, 1000, 8'hC1, 8'hC1, 1'b1, 604, 8'hC1, 1'b1, 7'h41, 10};

    // Reset values, then an idle bus with no request.
    repeat (3) @(negedge Clock);
    check("rst_e", oLCD_Enabled, 0);
    check("rst_rs", oLCD_RegisterSelect, 0);
    check("rst_rw", oLCD_ReadWrite, 0);
    check("rst_sf", oLCD_StrataFlashControl, 1);
    check("rst_busy", oBusy, 0);
    check("rst_valid", oRead_Valid, 0);
    check("rst_timeout", oTimeout, 0);
    check("rst_data", oRead_Data, 0);
    check("rst_bf", oBusyFlag, 0);
    check("rst_addr", oAddress, 0);
    Reset = 1'b1;
    idleOk = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge Clock);
      if (oLCD_ReadWrite || oLCD_Enabled || oBusy || oRead_Valid) idleOk = 1'b0;
    end
    check("idle_1000", idleOk, 1);

    for (int v = 0; v < 7; v++) begin
      modelBusy = vecs[v].nBusy; modelBusyByte = vecs[v].busyByte; modelFinal = vecs[v].finalByte;
      runTx(vecs[v].rs, vecs[v].poll, 1'b0);
      check($sformatf("v%0d_ended", v), txEnded, 1);
      check($sformatf("v%0d_busy_start", v), txBusyStart, 1);
      check($sformatf("v%0d_latency", v), txLatency, vecs[v].expLatency);
      check($sformatf("v%0d_valid", v), txValid, !vecs[v].expTimeout);
      check($sformatf("v%0d_timeout", v), txTimeout, vecs[v].expTimeout);
      check($sformatf("v%0d_data", v), txData, vecs[v].expData);
      check($sformatf("v%0d_bf", v), txBf, vecs[v].expBf);
      check($sformatf("v%0d_addr", v), txAddr, vecs[v].expAddr);
      check($sformatf("v%0d_pulses", v), txPulses, vecs[v].expPulses);
      check($sformatf("v%0d_e_width", v), txWidthOk, 1);
      check($sformatf("v%0d_e_gap", v), txGap, 65);
      check($sformatf("v%0d_rs", v), txRsOk, 1);
      check($sformatf("v%0d_busy_after", v), txBusyAfter, 0);
      check($sformatf("v%0d_pulse_after", v), txPulseAfter, 0);
    end

    // Request held through DONE: re-accepted in the IDLE cycle after DONE.
    modelBusy = 0; modelFinal = 8'h6E;
    runTx(1'b0, 1'b0, 1'b1);
    check("held_valid", txValid, 1);
    check("held_data", txData, 8'h6E);
    check("held_idle_gap", txBusyAfter, 0);
    @(posedge Clock);
    @(negedge Clock);
    iRead_Request = 1'b0;
    check("held_reaccept", oBusy, 1);

    // Busy-time request is ignored; reset lands mid E_L of the second read.
    for (int c = 1; c <= 70; c++) begin
      @(posedge Clock);
      @(negedge Clock);
      iRead_Request = (c >= 20 && c < 25);
    end
    check("rst_mid_in_e", oLCD_Enabled, 1);
    Reset = 1'b0;
    #1;
    check("rst_mid_e", oLCD_Enabled, 0);
    check("rst_mid_rw", oLCD_ReadWrite, 0);
    check("rst_mid_busy", oBusy, 0);
    check("rst_mid_data", oRead_Data, 0);
    check("rst_mid_addr", oAddress, 0);
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    idleOk = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clock);
      if (oRead_Valid || oBusy || oLCD_ReadWrite) idleOk = 1'b0;
    end
    check("rst_mid_quiet", idleOk, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
